// File: rtl/tree_pattern_sequencer_if.sv
// tree_pattern_sequencer_if: control inputs and code outputs of the tree pattern sequencer.
interface tree_pattern_sequencer_if;
    logic       en_i;
    logic       hold_i;
    logic       dir_i;
    logic       load_i;
    logic [3:0] load_code_i;
    logic [3:0] code_o;
    logic       code_stb_o;
    logic       at_end_o;
    modport master (output en_i, hold_i, dir_i, load_i, load_code_i, input code_o, code_stb_o, at_end_o);
    modport slave  (input en_i, hold_i, dir_i, load_i, load_code_i, output code_o, code_stb_o, at_end_o);
endinterface

// File: rtl/tree_pattern_sequencer.sv
// tree_pattern_sequencer: prescaled 0..LAST code stepper for the 7-segment tree decoder.
// Define BLINK_EN to blink the held code against BLANK_CODE while paused.
module tree_pattern_sequencer #(
    parameter int          DIV        = 25_000_000,
    parameter int          DIV_W      = 25,
    parameter int          LAST       = 15,
    parameter int          WRAP       = 1,
    parameter logic [3:0]  BLANK_CODE = 4'hA
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tree_pattern_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HOLD} state_t;
    localparam logic [3:0]       LAST_C = 4'(LAST);
    localparam logic [DIV_W-1:0] TOP    = DIV_W'(DIV - 1);
    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [3:0]       code_q, code_d, out_q, out_d;
    logic             end_dir_q, end_dir_d;
    logic             stb_q, at_end_q;
    logic             phase_d;
    logic             tick, at_lim;
`ifdef BLINK_EN
    logic             phase_q;
`endif
    assign tick   = presc_q == TOP;
    assign at_lim = bus.dir_i ? (code_q == 4'd0) : (code_q == LAST_C);
    always_comb begin
        state_d   = state_q;
        presc_d   = '0;
        code_d    = code_q;
        end_dir_d = end_dir_q;
        phase_d   = 1'b0;
        if (!bus.en_i) begin
            state_d = IDLE;
            code_d  = 4'd0;
        end else if (bus.load_i) begin
            state_d = RUN;
            code_d  = (bus.load_code_i > LAST_C) ? LAST_C : bus.load_code_i;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (bus.hold_i) state_d = PAUSE;
                    else if (!tick) presc_d = presc_q + 1'b1;
                    else if (!at_lim) code_d = bus.dir_i ? code_q - 4'd1 : code_q + 4'd1;
                    else if (WRAP != 0) code_d = bus.dir_i ? LAST_C : 4'd0;
                    else begin
                        state_d   = HOLD;
                        end_dir_d = bus.dir_i;
                    end
                end
                PAUSE: begin
                    if (!bus.hold_i) state_d = RUN;
`ifdef BLINK_EN
                    else begin
                        presc_d = tick ? '0 : presc_q + 1'b1;
                        phase_d = phase_q ^ tick;
                    end
`endif
                end
                HOLD: if (bus.dir_i != end_dir_q) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end
    // The visible code is what the decoder sees, so the strobe follows it rather than code_q.
    assign out_d = phase_d ? BLANK_CODE : code_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            code_q    <= 4'd0;
            out_q     <= 4'd0;
            end_dir_q <= 1'b0;
            stb_q     <= 1'b0;
            at_end_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            code_q    <= code_d;
            out_q     <= out_d;
            end_dir_q <= end_dir_d;
            stb_q     <= out_d != out_q;
            at_end_q  <= state_d == HOLD;
        end
    end
`ifdef BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= 1'b0;
        else phase_q <= phase_d;
    end
`endif
    assign bus.code_o     = out_q;
    assign bus.code_stb_o = stb_q;
    assign bus.at_end_o   = at_end_q;
endmodule

// File: tb/tb_tree_pattern_sequencer.sv
// tb_tree_pattern_sequencer: directed checks of a wrapping and a stopping sequencer, DIV=4, LAST=5.
module tb_tree_pattern_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
`ifdef BLINK_EN
    localparam logic [3:0] PAUSED = 4'hA;
`else
    localparam logic [3:0] PAUSED = 4'h3;
`endif
    tree_pattern_sequencer_if iw ();
    tree_pattern_sequencer_if is ();
    tree_pattern_sequencer #(.DIV(4), .DIV_W(3), .LAST(5), .WRAP(1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(iw));
    tree_pattern_sequencer #(.DIV(4), .DIV_W(3), .LAST(5), .WRAP(0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(is));
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    initial begin
        {iw.en_i, iw.hold_i, iw.dir_i, iw.load_i, iw.load_code_i} = '0;
        {is.en_i, is.hold_i, is.dir_i, is.load_i, is.load_code_i} = '0;
        step(2);
        chk("rst_code", iw.code_o, 4'd0);
        chk("rst_stb", {3'b0, iw.code_stb_o}, 4'd0);
        chk("rst_at_end", {3'b0, iw.at_end_o}, 4'd0);
        rst_n = 1'b1;
        iw.en_i = 1'b1;
        step(4);
        chk("pre_first_step", iw.code_o, 4'd0);
        chk("pre_first_stb", {3'b0, iw.code_stb_o}, 4'd0);
        step(1);
        chk("first_step", iw.code_o, 4'd1);
        chk("first_stb", {3'b0, iw.code_stb_o}, 4'd1);
        step(1);
        chk("stb_one_cycle", {3'b0, iw.code_stb_o}, 4'd0);
        step(3);
        chk("second_step", iw.code_o, 4'd2);
        chk("second_stb", {3'b0, iw.code_stb_o}, 4'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_code", iw.code_o, 4'd0);
        chk("async_rst_stb", {3'b0, iw.code_stb_o}, 4'd0);
        step(1);
        rst_n = 1'b1;
        step(5);
        chk("after_rst_step", iw.code_o, 4'd1);
        step(16);
        chk("reach_last", iw.code_o, 4'd5);
        step(4);
        chk("wrap_up", iw.code_o, 4'd0);
        chk("wrap_up_stb", {3'b0, iw.code_stb_o}, 4'd1);
        iw.dir_i = 1'b1;
        step(4);
        chk("wrap_down", iw.code_o, 4'd5);
        chk("wrap_down_stb", {3'b0, iw.code_stb_o}, 4'd1);
        step(4);
        chk("count_down", iw.code_o, 4'd4);
        step(4);
        chk("down_to_3", iw.code_o, 4'd3);
        iw.hold_i = 1'b1;
        step(1);
        chk("pause_enter", iw.code_o, 4'd3);
        step(4);
        chk("pause_4", iw.code_o, PAUSED);
        step(4);
        chk("pause_8", iw.code_o, 4'd3);
        step(4);
        chk("pause_12", iw.code_o, PAUSED);
        iw.hold_i = 1'b0;
        step(1);
        chk("resume_restore", iw.code_o, 4'd3);
        step(3);
        chk("resume_no_early", iw.code_o, 4'd3);
        step(1);
        chk("resume_step", iw.code_o, 4'd2);
        iw.load_i = 1'b1;
        iw.load_code_i = 4'd9;
        step(1);
        chk("load_clamp", iw.code_o, 4'd5);
        chk("load_stb", {3'b0, iw.code_stb_o}, 4'd1);
        iw.load_i = 1'b0;
        step(3);
        iw.load_i = 1'b1;
        iw.load_code_i = 4'd2;
        iw.hold_i = 1'b1;
        step(1);
        chk("load_over_tick_hold", iw.code_o, 4'd2);
        iw.load_i = 1'b0;
        iw.hold_i = 1'b0;
        step(4);
        chk("load_enters_run", iw.code_o, 4'd1);
        iw.dir_i = 1'b0;
        step(12);
        chk("up_to_4", iw.code_o, 4'd4);
        iw.en_i = 1'b0;
        step(1);
        chk("en_off_code", iw.code_o, 4'd0);
        chk("en_off_stb", {3'b0, iw.code_stb_o}, 4'd1);
        step(2);
        chk("idle_stays", iw.code_o, 4'd0);
        iw.en_i = 1'b1;
        step(4);
        chk("idle_run_no_early", iw.code_o, 4'd0);
        step(1);
        chk("idle_run_step", iw.code_o, 4'd1);
        is.en_i = 1'b1;
        step(21);
        chk("stop_reach_last", is.code_o, 4'd5);
        chk("stop_not_yet_end", {3'b0, is.at_end_o}, 4'd0);
        step(4);
        chk("stop_hold_code", is.code_o, 4'd5);
        chk("stop_at_end", {3'b0, is.at_end_o}, 4'd1);
        chk("stop_no_stb", {3'b0, is.code_stb_o}, 4'd0);
        step(20);
        chk("stop_hold_20", is.code_o, 4'd5);
        chk("stop_at_end_20", {3'b0, is.at_end_o}, 4'd1);
        is.dir_i = 1'b1;
        step(1);
        chk("stop_leave_end", {3'b0, is.at_end_o}, 4'd0);
        chk("stop_leave_code", is.code_o, 4'd5);
        step(4);
        chk("stop_down_step", is.code_o, 4'd4);
        chk("stop_down_at_end", {3'b0, is.at_end_o}, 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
